// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, FSM state encoding and status-flag bit positions for the ALU datapath.
package alu_pkg;
    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int NIBBLES = WIDTH / SLICE;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_B = 3;
endpackage

// File: rtl/sub16_serial_if.sv
// sub16_serial_if: start/busy/done handshake, operands, result and flags of the serial subtractor.
interface sub16_serial_if;
    import alu_pkg::*;
    logic start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic bi;
    logic busy;
    logic done;
    logic [WIDTH-1:0] o;
    logic bo;
    logic zero;
    logic neg;
    logic ovf;
    modport master (output start, a, b, bi, input busy, done, o, bo, zero, neg, ovf);
    modport slave (input start, a, b, bi, output busy, done, o, bo, zero, neg, ovf);
endinterface

// File: rtl/sub16_serial_sub4b.sv
// sub4b: combinational 4-bit borrow slice, r = a + ~b + ci with carry-out co.
module sub4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] r,
    output logic       co
);
    assign {co, r} = {1'b0, a} + {1'b0, ~b} + 5'(ci);
endmodule

// File: rtl/sub16_serial.sv
// sub16_serial: 16-bit a - b - bi computed one nibble per clock through a single borrow slice.
module sub16_serial
    import alu_pkg::*;
(
    input logic clk,
    input logic rst_n,
    sub16_serial_if.slave bus
);
    state_t st, nx;
    logic [1:0] cnt;
    logic [WIDTH-1:0] opa, opb, o_q, full;
    logic [WIDTH-SLICE-1:0] res;
    logic [SLICE-1:0] r;
    logic [3:0] fl_q, fl_nx;
    logic cy, co, last, accept;

    sub4b u_slice (.a(opa[SLICE-1:0]), .b(opb[SLICE-1:0]), .ci(cy), .r(r), .co(co));

    assign last = cnt == 2'(NIBBLES - 1);
    assign accept = bus.start && st != S_RUN;
    assign full = {r, res};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) st <= S_IDLE;
        else st <= nx;

    always_comb
        nx = st == S_RUN ? (last ? S_DONE : S_RUN) : (bus.start ? S_RUN : S_IDLE);

    // operands are shifted down, so on the last nibble opa/opb[3] hold the original sign bits
    always_comb begin
        fl_nx = '0;
        fl_nx[FLAG_Z] = full == '0;
        fl_nx[FLAG_N] = full[WIDTH-1];
        fl_nx[FLAG_V] = (opa[SLICE-1] != opb[SLICE-1]) && (full[WIDTH-1] != opa[SLICE-1]);
        fl_nx[FLAG_B] = ~co;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            opa <= '0;
            opb <= '0;
            res <= '0;
            cy <= 1'b0;
            cnt <= '0;
            o_q <= '0;
            fl_q <= '0;
        end else if (accept) begin
            opa <= bus.a;
            opb <= bus.b;
            cy <= ~bus.bi;
            cnt <= '0;
        end else if (st == S_RUN) begin
            opa <= opa >> SLICE;
            opb <= opb >> SLICE;
            res <= {r, res[WIDTH-SLICE-1:SLICE]};
            cy <= co;
            cnt <= cnt + 2'd1;
            if (last) begin
                o_q <= full;
                fl_q <= fl_nx;
            end
        end

    always_comb begin
        bus.busy = st == S_RUN;
        bus.done = st == S_DONE;
        bus.o = o_q;
        bus.zero = fl_q[FLAG_Z];
        bus.neg = fl_q[FLAG_N];
        bus.ovf = fl_q[FLAG_V];
        bus.bo = fl_q[FLAG_B];
    end
endmodule

// File: tb/tb_sub16_serial.sv
// tb_sub16_serial: directed vectors with literal expectations plus a cycle-level arithmetic reference model.
module tb_sub16_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    sub16_serial_if bus ();
    sub16_serial dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // reference: ph 0 idle, 1..4 busy, 5 done; results from plain 17-bit arithmetic
    int ph = 0;
    logic [15:0] po, mo;
    logic pbo, pa15, pb15, mbo, mz, mn, mv;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ph <= 0;
            mo <= '0;
            mbo <= 1'b0;
            mz <= 1'b0;
            mn <= 1'b0;
            mv <= 1'b0;
        end else if (ph >= 1 && ph <= 3) ph <= ph + 1;
        else if (ph == 4) begin
            ph <= 5;
            mo <= po;
            mbo <= pbo;
            mz <= po == 16'h0;
            mn <= po[15];
            mv <= (pa15 != pb15) && (po[15] != pa15);
        end else if (bus.start) begin
            ph <= 1;
            {pbo, po} <= {1'b0, bus.a} - {1'b0, bus.b} - 17'(bus.bi);
            pa15 <= bus.a[15];
            pb15 <= bus.b[15];
        end else ph <= 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model busy", 32'(bus.busy), 32'(ph >= 1 && ph <= 4));
        chk("model done", 32'(bus.done), 32'(ph == 5));
        chk("model o", 32'(bus.o), 32'(mo));
        chk("model flags", {28'h0, bus.bo, bus.zero, bus.neg, bus.ovf}, {28'h0, mbo, mz, mn, mv});
        chk("busy&done", 32'(bus.busy && bus.done), 32'h0);
    end

    task automatic wait_done(input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 12);
        if (!bus.done) chk({nm, " timeout"}, 32'h0, 32'h1);
    endtask

    task automatic check_res(input string nm, input logic [15:0] eo, input logic [3:0] ef);
        chk({nm, " o"}, 32'(bus.o), 32'(eo));
        chk({nm, " bo/z/n/v"}, {28'h0, bus.bo, bus.zero, bus.neg, bus.ovf}, {28'h0, ef});
    endtask

    task automatic run_op(input string nm, input logic [15:0] x, input logic [15:0] y, input logic c,
                          input logic [15:0] eo, input logic [3:0] ef);
        int n;
        @(negedge clk);
        bus.a = x;
        bus.b = y;
        bus.bi = c;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = ~x;
        bus.b = ~y;
        bus.bi = ~c;
        wait_done(nm, n);
        chk({nm, " latency"}, 32'(n), 32'd4);
        check_res(nm, eo, ef);
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bi = 1'b0;
        repeat (2) @(negedge clk);
        check_res("reset", 16'h0, 4'b0000);
        chk("reset busy/done", {30'h0, bus.busy, bus.done}, 32'h0);
        rst_n = 1'b1;
        // flags literal order: bo, zero, neg, ovf
        run_op("basic", 16'h0005, 16'h0003, 1'b0, 16'h0002, 4'b0000);
        run_op("borrow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b1010);
        run_op("ovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0001);
        run_op("bi zero", 16'h1234, 16'h1233, 1'b1, 16'h0000, 4'b0100);
        run_op("xnibble", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 4'b0000);
        run_op("pos-neg ovf", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 4'b1011);

        // a start during RUN must be ignored
        @(negedge clk);
        bus.a = 16'h0010;
        bus.b = 16'h0001;
        bus.bi = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 16'hFFFF;
        bus.b = 16'hFFFF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ignore", n);
        chk("ignore latency", 32'(n), 32'd2);
        check_res("ignore", 16'h000F, 4'b0000);
        @(negedge clk);

        // start held through DONE restarts immediately
        bus.a = 16'h0009;
        bus.b = 16'h0004;
        bus.bi = 1'b0;
        bus.start = 1'b1;
        wait_done("b2b first", n);
        check_res("b2b first", 16'h0005, 4'b0000);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b restart busy", 32'(bus.busy), 32'h1);
        n = 1;
        while (!bus.done && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("b2b spacing", 32'(n), 32'd5);
        check_res("b2b second", 16'h0005, 4'b0000);

        // asynchronous reset in the middle of a run
        @(negedge clk);
        bus.a = 16'hAAAA;
        bus.b = 16'h5555;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst busy/done", {30'h0, bus.busy, bus.done}, 32'h0);
        check_res("async rst", 16'h0, 4'b0000);
        repeat (6) begin
            @(negedge clk);
            chk("no done after abort", 32'(bus.done), 32'h0);
        end
        rst_n = 1'b1;
        run_op("after rst", 16'h0003, 16'h0003, 1'b0, 16'h0000, 4'b0100);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
